// File: rtl/tcrc_reg_n_pkg.sv
// Shared definitions for the bit-serial CRC register: FSM encoding and CAN CRC-15 constants.
package tcrc_reg_n_pkg;

  localparam int          CAN_CRC15_WIDTH = 15;
  localparam logic [14:0] CAN_CRC15_POLY  = 15'h4599;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_SHIFT = 2'd2
  } tcrc_state_e;

endpackage

// File: rtl/tcrc_lfsr_step.sv
// One message bit of a non-reflected CRC: feedback is data XOR register MSB.
module tcrc_lfsr_step #(
  parameter int               WIDTH = 15,
  parameter logic [WIDTH-1:0] POLY  = 15'h4599
) (
  input  logic [WIDTH-1:0] crc_in,
  input  logic             data_in,
  output logic [WIDTH-1:0] crc_out
);

  logic fb;

  assign fb      = data_in ^ crc_in[WIDTH-1];
  assign crc_out = {crc_in[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/tcrc_reg_n.sv
// Bit-serial CRC generator/checker: accumulates in CALC, then shifts the remainder out MSB first.
module tcrc_reg_n
  import tcrc_reg_n_pkg::*;
#(
  parameter int               WIDTH = CAN_CRC15_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = CAN_CRC15_POLY,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             send,
  input  logic             abort,
  input  logic             load,
  input  logic [WIDTH-1:0] preload,
  input  logic             data_in,
  output logic [WIDTH-1:0] crc,
  output logic             crc_zero,
  output logic             tx_bit,
  output logic             busy,
  output logic             done,
  output tcrc_state_e      state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  tcrc_state_e      state_q, state_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] crc_step;
  logic             send_ok;
  logic             last_bit;

  tcrc_lfsr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .crc_in  (crc_q),
    .data_in (data_in),
    .crc_out (crc_step)
  );

  // send only has meaning while accumulating; elsewhere it falls through
  assign send_ok  = send && (state_q == ST_CALC);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      crc_q   <= INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_CALC;
    end else if (send_ok) begin
      state_d = ST_SHIFT;
    end else if (enable && !load && (state_q == ST_SHIFT) && last_bit) begin
      state_d = ST_IDLE;
    end
  end

  // Register, counter and done pulse; load wins over the per-state update
  always_comb begin
    crc_d  = crc_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      crc_d = INIT;
      cnt_d = '0;
    end else if (send_ok) begin
      cnt_d = '0;
    end else if (enable && load) begin
      crc_d = preload;
    end else if (enable) begin
      case (state_q)
        ST_CALC: crc_d = crc_step;
        ST_SHIFT: begin
          crc_d = {crc_q[WIDTH-2:0], 1'b0};
          if (last_bit) begin
            cnt_d  = '0;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == ST_CALC) || (state_q == ST_SHIFT);
    tx_bit    = (state_q == ST_SHIFT) ? crc_q[WIDTH-1] : 1'b0;
    done      = done_q;
    crc       = crc_q;
    crc_zero  = (crc_q == '0);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_tcrc_reg_n.sv
// Directed bench for tcrc_reg_n with default CAN CRC-15 parameters and hand-computed vectors.
module tb_tcrc_reg_n;
  import tcrc_reg_n_pkg::*;

  localparam int W = 15;

  logic          clock;
  logic          reset;
  logic          enable, start, send, abort, load, data_in;
  logic [W-1:0]  preload;
  logic [W-1:0]  crc;
  logic          crc_zero, tx_bit, busy, done;
  tcrc_state_e   state_dbg;

  int            n_checks;
  int            n_fail;
  logic          exp_q[$];

  tcrc_reg_n dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .start     (start),
    .send      (send),
    .abort     (abort),
    .load      (load),
    .preload   (preload),
    .data_in   (data_in),
    .crc       (crc),
    .crc_zero  (crc_zero),
    .tx_bit    (tx_bit),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    enable  = 1'b0;
    start   = 1'b0;
    send    = 1'b0;
    abort   = 1'b0;
    load    = 1'b0;
    data_in = 1'b0;
    preload = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [W-1:0] tx_pat;
  logic [16:0]  msg;
  logic         exp_bit;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    reset = 1'b0;
    #3;
    check("rst_crc", 32'(crc), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tx", 32'(tx_bit), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_zero", 32'(crc_zero), 32'h1);
    cycle();
    reset = 1'b1;

    // message "10" then shift-out
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("start_state", 32'(state_dbg), 32'(ST_CALC));
    check("start_busy", 32'(busy), 32'h1);
    enable = 1'b1; data_in = 1'b1;
    cycle();
    check("calc_bit1", 32'(crc), 32'h4599);
    data_in = 1'b0;
    cycle();
    check("calc_bit0", 32'(crc), 32'h4EAB);
    enable = 1'b0; data_in = 1'b1;
    cycle();
    cycle();
    check("hold_en0", 32'(crc), 32'h4EAB);
    send = 1'b1;
    cycle();
    send = 1'b0;
    check("send_state", 32'(state_dbg), 32'(ST_SHIFT));
    check("send_crc", 32'(crc), 32'h4EAB);
    tx_pat = 15'b100111010101011;
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(tx_pat[i]);
    enable = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (i == 5) begin
        enable = 1'b0;
        cycle();
        check("shift_pause_done", 32'(done), 32'h0);
        check("shift_pause_state", 32'(state_dbg), 32'(ST_SHIFT));
        enable = 1'b1;
      end
      send = (i == 8);
      exp_bit = exp_q.pop_front();
      check($sformatf("tx_bit[%0d]", i), 32'(tx_bit), 32'(exp_bit));
      cycle();
      check($sformatf("done[%0d]", i), 32'(done), (i == W - 1) ? 32'h1 : 32'h0);
    end
    send = 1'b0; enable = 1'b0;
    check("shift_end_crc", 32'(crc), 32'h0);
    check("shift_end_busy", 32'(busy), 32'h0);
    check("shift_end_state", 32'(state_dbg), 32'(ST_IDLE));
    check("shift_end_tx", 32'(tx_bit), 32'h0);
    cycle();
    check("done_one_cycle", 32'(done), 32'h0);

    // message followed by its own CRC leaves zero remainder
    start = 1'b1;
    cycle();
    start = 1'b0;
    enable = 1'b1;
    msg = {2'b10, 15'h4EAB};
    for (int i = 16; i >= 0; i--) begin
      data_in = msg[i];
      cycle();
      if (i == 15) check("residue_mid_zero", 32'(crc_zero), 32'h0);
    end
    check("residue_zero", 32'(crc_zero), 32'h1);
    check("residue_crc", 32'(crc), 32'h0);

    // load in CALC, then abort racing a load
    idle_inputs();
    start = 1'b1;
    cycle();
    start = 1'b0;
    enable = 1'b1; load = 1'b1; preload = 15'h1234;
    cycle();
    load = 1'b0;
    check("load_crc", 32'(crc), 32'h1234);
    check("load_state", 32'(state_dbg), 32'(ST_CALC));
    data_in = 1'b0;
    cycle();
    check("after_load_step", 32'(crc), 32'h2468);
    load = 1'b1; preload = 15'h7FFF; abort = 1'b1;
    cycle();
    idle_inputs();
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    check("abort_crc", 32'(crc), 32'h2468);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    enable = 1'b1; load = 1'b1; preload = 15'h0ABC;
    cycle();
    idle_inputs();
    check("idle_load_crc", 32'(crc), 32'h0ABC);
    check("idle_load_state", 32'(state_dbg), 32'(ST_IDLE));
    send = 1'b1;
    cycle();
    send = 1'b0;
    check("idle_send_ignored", 32'(state_dbg), 32'(ST_IDLE));

    // restart from CALC; start beats the bit update
    start = 1'b1;
    cycle();
    start = 1'b0;
    enable = 1'b1; data_in = 1'b1;
    cycle();
    cycle();
    check("calc_11", 32'(crc), 32'h0B32);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("restart_calc_crc", 32'(crc), 32'h0);
    check("restart_calc_state", 32'(state_dbg), 32'(ST_CALC));

    // asynchronous reset mid-SHIFT
    data_in = 1'b1;
    cycle();
    data_in = 1'b0;
    cycle();
    enable = 1'b0; send = 1'b1;
    cycle();
    send = 1'b0; enable = 1'b1;
    repeat (7) cycle();
    enable = 1'b0;
    check("shift7_crc", 32'(crc), 32'h5580);
    check("shift7_tx", 32'(tx_bit), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_crc", 32'(crc), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("async_rst_tx", 32'(tx_bit), 32'h0);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_no_done", 32'(done), 32'h0);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("post_rst_no_done", 32'(done), 32'h0);
    end
    enable = 1'b0;

    // start during SHIFT restarts in CALC
    start = 1'b1;
    cycle();
    start = 1'b0;
    enable = 1'b1; data_in = 1'b1;
    cycle();
    enable = 1'b0; send = 1'b1;
    cycle();
    send = 1'b0; enable = 1'b1;
    repeat (3) cycle();
    check("shift3_crc", 32'(crc), 32'h2CC8);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("shift_restart_state", 32'(state_dbg), 32'(ST_CALC));
    check("shift_restart_crc", 32'(crc), 32'h0);
    check("shift_restart_busy", 32'(busy), 32'h1);
    enable = 1'b0;
    cycle();
    check("shift_restart_no_done", 32'(done), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
